// File: rtl/hbram_pkg.sv
// Shared types and constants for the HyperBus RAM burst executor.
// State encodings and the burst-length counter width live here so the bench and RTL agree.
package hbram_pkg;

    localparam int LEN_W = 11;
    localparam logic [LEN_W-1:0] LEN_MAX = 11'd1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_DONE  = 3'd4
    } hbram_state_e;

    // True when the beat being accepted is the final one of the burst.
    function automatic logic is_last_beat(input logic [LEN_W-1:0] cnt,
                                          input logic [LEN_W-1:0] len);
        return (LEN_W'(cnt + LEN_W'(1)) == len);
    endfunction

endpackage

// File: rtl/hbram_burst_exec.sv
// Burst executor: accepts one command in IDLE, issues it to the memory controller,
// then streams write beats from the write FIFO or read beats into the read FIFO.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid never waits on ready, and command fields hold steady while valid.
// Read beats have no backpressure and are counted even when dropped on a full FIFO.
module hbram_burst_exec
    import hbram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  ram_clock,
    input  logic                  ram_reset_n,
    input  logic                  ram_en,
    input  logic                  ram_rw_ctrl,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [LEN_W-1:0]      burst_len,
    output logic                  operating,
    output logic                  busy,
    output logic                  wfifo_rd_en,
    input  logic [DATA_WIDTH-1:0] wfifo_rd_data,
    input  logic                  wfifo_empty,
    output logic                  rfifo_wr_en,
    output logic [DATA_WIDTH-1:0] rfifo_wr_data,
    input  logic                  rfifo_full,
    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic                  mem_cmd_rw,
    output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
    output logic [LEN_W-1:0]      mem_cmd_len,
    output logic                  mem_wdata_valid,
    input  logic                  mem_wdata_ready,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rdata_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rd_ovf_err,
    output logic [2:0]            dbg_state
);

    hbram_state_e          state_q, state_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  ovf_q, ovf_d;
    logic                  last_beat;

    assign last_beat = is_last_beat(cnt_q, len_q);

    always_ff @(posedge ram_clock or negedge ram_reset_n) begin
        if (!ram_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rw_d            = rw_q;
        addr_d          = addr_q;
        len_d           = len_q;
        ovf_d           = ovf_q;
        mem_cmd_valid   = 1'b0;
        mem_wdata_valid = 1'b0;
        mem_wdata       = '0;
        wfifo_rd_en     = 1'b0;
        rfifo_wr_en     = 1'b0;
        rfifo_wr_data   = '0;

        case (state_q)
            ST_IDLE: begin
                // A zero-length command is silently dropped.
                if (ram_en && (burst_len != '0)) begin
                    rw_d    = ram_rw_ctrl;
                    addr_d  = ram_addr;
                    len_d   = burst_len;
                    cnt_d   = '0;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                mem_cmd_valid = 1'b1;
                if (mem_cmd_ready) begin
                    state_d = rw_q ? ST_RDATA : ST_WDATA;
                end
            end
            ST_WDATA: begin
                mem_wdata_valid = ~wfifo_empty;
                mem_wdata       = wfifo_rd_data;
                wfifo_rd_en     = ~wfifo_empty & mem_wdata_ready;
                if (wfifo_rd_en) begin
                    cnt_d = LEN_W'(cnt_q + LEN_W'(1));
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RDATA: begin
                rfifo_wr_en   = mem_rdata_valid & ~rfifo_full;
                rfifo_wr_data = mem_rdata;
                if (mem_rdata_valid) begin
                    cnt_d = LEN_W'(cnt_q + LEN_W'(1));
                    if (rfifo_full) begin
                        ovf_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy         = (state_q != ST_IDLE);
    assign operating    = (state_q != ST_IDLE);
    assign mem_cmd_rw   = rw_q;
    assign mem_cmd_addr = addr_q;
    assign mem_cmd_len  = len_q;
    assign rd_ovf_err   = ovf_q;
    assign dbg_state    = state_q;

endmodule
